// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_e : control FSM states (idle, running, product held)
//   clog2   : bits needed to count 0 .. value-1
//   abs_w   : magnitude of a width-bit two's-complement value, returned unsigned
package seq_mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Valid for width < 64. The most-negative value maps to 2^(width-1), which still fits
    // in width bits when read as unsigned.
    function automatic logic [63:0] abs_w(input logic [63:0] value, input int unsigned width);
        logic [63:0] mask;
        logic        sign;
        mask = (64'(1) << width) - 64'(1);
        sign = |((value >> (width - 1)) & 64'(1));
        if (sign) begin
            return (~value + 64'(1)) & mask;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Handshake bundle for seq_mult.
//   input side : in_valid/in_ready, in_signed, multiplier, multiplicand
//   output side: out_valid/out_ready, product (2*WIDTH bits)
//   status     : busy
// slave is the multiplier itself, master is whoever feeds and drains it.
interface seq_mult_if #(
    parameter int unsigned WIDTH = 8
);

    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   multiplier;
    logic [WIDTH-1:0]   multiplicand;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport slave (
        input  in_valid, in_signed, multiplier, multiplicand, out_ready,
        output in_ready, out_valid, product, busy
    );

    modport master (
        output in_valid, in_signed, multiplier, multiplicand, out_ready,
        input  in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, signed or unsigned per
// transaction. Signed operands are reduced to magnitudes on accept and the product is negated
// on the way out, so the datapath itself is purely unsigned.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; abandons any operation in flight
//   bus   : seq_mult_if slave (operand handshake, product handshake, busy)
// WIDTH >= 2. EARLY_EXIT = 1 stops as soon as no set multiplier bits remain.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    seq_mult_if.slave bus
);

    localparam int unsigned CNT_W = clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [WIDTH-1:0] op_a_mag;
    logic [WIDTH-1:0] op_b_mag;
    logic             op_neg;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    sum;
    logic [WIDTH-1:0] mag_a_shr;
    logic             last;

    assign bus.in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = (state_q == StRun);

    assign op_a_mag = bus.in_signed ? WIDTH'(abs_w(64'(bus.multiplier), WIDTH))
                                    : bus.multiplier;
    assign op_b_mag = bus.in_signed ? WIDTH'(abs_w(64'(bus.multiplicand), WIDTH))
                                    : bus.multiplicand;
    assign op_neg   = bus.in_signed && (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1]);

    // Partial product for the current multiplier bit, weighted by the bit position.
    assign addend    = mag_a_q[0] ? ({{WIDTH{1'b0}}, mag_b_q} << cnt_q) : '0;
    assign sum       = acc_q + addend;
    assign mag_a_shr = mag_a_q >> 1;
    assign last      = (cnt_q == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && (mag_a_shr == '0));

    always_comb begin
        state_d     = state_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        product_d   = product_q;

        case (state_q)
            StIdle: ;
            StRun: begin
                acc_d   = sum;
                mag_a_d = mag_a_shr;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    product_d   = neg_q ? -sum : sum;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept is only possible from idle or from a product being taken, so a new
        // operation can start on the same edge the previous product leaves.
        if (accept) begin
            state_d = StRun;
            mag_a_d = op_a_mag;
            mag_b_d = op_b_mag;
            neg_d   = op_neg;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            state_q     <= state_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed 8-bit vectors on fixed-latency and early-exit
// instances, backpressure and mid-operation reset sequences, then a 16-bit randomized run
// against a reference multiply with random consumer stalls.
module tb_seq_mult;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    seq_mult_if #(.WIDTH(8))  if_ee0 ();
    seq_mult_if #(.WIDTH(8))  if_ee1 ();
    seq_mult_if #(.WIDTH(16)) if_w16 ();

    seq_mult #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_ee0 (.clk(clk), .rst_n(rst_n), .bus(if_ee0));
    seq_mult #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee1 (.clk(clk), .rst_n(rst_n), .bus(if_ee1));
    seq_mult #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if_w16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 8-bit drive; sel_ee picks which instance sees in_valid and whose outputs we read.
    logic        sel_ee;
    logic        in_valid8, in_signed8, out_ready8;
    logic [7:0]  a8, b8;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] product8;

    assign if_ee0.in_valid     = in_valid8 && !sel_ee;
    assign if_ee1.in_valid     = in_valid8 && sel_ee;
    assign if_ee0.in_signed    = in_signed8;
    assign if_ee1.in_signed    = in_signed8;
    assign if_ee0.multiplier   = a8;
    assign if_ee1.multiplier   = a8;
    assign if_ee0.multiplicand = b8;
    assign if_ee1.multiplicand = b8;
    assign if_ee0.out_ready    = out_ready8;
    assign if_ee1.out_ready    = out_ready8;

    assign in_ready8  = sel_ee ? if_ee1.in_ready  : if_ee0.in_ready;
    assign out_valid8 = sel_ee ? if_ee1.out_valid : if_ee0.out_valid;
    assign busy8      = sel_ee ? if_ee1.busy      : if_ee0.busy;
    assign product8   = sel_ee ? if_ee1.product   : if_ee0.product;

    typedef struct {
        logic        ee;
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_p;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Issue one 8-bit operation with out_ready high; returns product and accept-to-valid cycles.
    task automatic run8(input logic ee, input logic sgn, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] prod, output int lat);
        sel_ee     = ee;
        in_signed8 = sgn;
        a8         = a;
        b8         = b;
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        prod = product8;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mul(input logic s, input logic [15:0] a,
                                            input logic [15:0] b);
        logic signed [31:0] sa, sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        if (s) return sa * sb;
        return {16'b0, a} * {16'b0, b};
    endfunction

    logic [31:0] exp_q[$];
    int          got;

    initial begin
        logic [15:0] p;
        int          lat;
        int          n;

        vecs[0]  = '{1'b0, 1'b0, 8'd200, 8'd150, 16'h7530, 8};
        vecs[1]  = '{1'b0, 1'b1, 8'h80,  8'h80,  16'h4000, 8};
        vecs[2]  = '{1'b0, 1'b1, 8'hF9,  8'h09,  16'hFFC1, 8};
        vecs[3]  = '{1'b0, 1'b1, 8'h7F,  8'hFF,  16'hFF81, 8};
        vecs[4]  = '{1'b0, 1'b0, 8'hFF,  8'hFF,  16'hFE01, 8};
        vecs[5]  = '{1'b1, 1'b0, 8'h00,  8'h55,  16'h0000, 1};
        vecs[6]  = '{1'b1, 1'b0, 8'h05,  8'h33,  16'h00FF, 3};
        vecs[7]  = '{1'b1, 1'b0, 8'h80,  8'h03,  16'h0180, 8};
        vecs[8]  = '{1'b1, 1'b1, 8'hF9,  8'h09,  16'hFFC1, 3};
        vecs[9]  = '{1'b1, 1'b1, 8'h80,  8'h80,  16'h4000, 8};
        vecs[10] = '{1'b1, 1'b1, 8'h01,  8'h80,  16'hFF80, 1};

        sel_ee = 1'b0; in_valid8 = 1'b0; in_signed8 = 1'b0; out_ready8 = 1'b1;
        a8 = '0; b8 = '0;
        if_w16.in_valid = 1'b0; if_w16.in_signed = 1'b0; if_w16.out_ready = 1'b1;
        if_w16.multiplier = '0; if_w16.multiplicand = '0;
        got = 0;

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset ee0 out_valid", if_ee0.out_valid, 0);
        check("reset ee0 product", if_ee0.product, 0);
        check("reset ee0 busy", if_ee0.busy, 0);
        check("reset ee1 out_valid", if_ee1.out_valid, 0);
        check("reset w16 out_valid", if_w16.out_valid, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("release ee0 in_ready", if_ee0.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            run8(vecs[i].ee, vecs[i].sgn, vecs[i].a, vecs[i].b, p, lat);
            check($sformatf("vec%0d product", i), p, vecs[i].exp_p);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
        end

        // Backpressure: product held 5 cycles, then a same-edge hand-over to a new operation
        sel_ee = 1'b0; in_signed8 = 1'b0; a8 = 8'd3; b8 = 8'd4;
        out_ready8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp latency", n, 8);
        a8 = 8'd10; b8 = 8'd10; in_valid8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp hold%0d out_valid", k), out_valid8, 1);
            check($sformatf("bp hold%0d product", k), product8, 16'd12);
            check($sformatf("bp hold%0d in_ready", k), in_ready8, 0);
            @(posedge clk);
            #1;
        end
        out_ready8 = 1'b1;
        #1;
        check("bp handover in_ready", in_ready8, 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        check("bp no bubble busy", busy8, 1);
        check("bp out_valid dropped", out_valid8, 0);
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp second latency", n, 8);
        check("bp second product", product8, 16'd100);
        @(posedge clk);
        #1;

        // Reset in the middle of a run: nothing may be delivered afterwards
        sel_ee = 1'b0; a8 = 8'd200; b8 = 8'd150; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun busy before reset", busy8, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrun reset out_valid", out_valid8, 0);
        check("midrun reset product", product8, 0);
        check("midrun reset busy", busy8, 0);
        #4 rst_n = 1'b1;
        #1;
        check("midrun release in_ready", in_ready8, 1);
        repeat (10) @(posedge clk);
        #1;
        check("midrun abandoned no output", out_valid8, 0);
        run8(1'b0, 1'b0, 8'd3, 8'd4, p, lat);
        check("after reset product", p, 16'd12);
        check("after reset latency", lat, 8);

        // 16-bit randomized mixed-mode traffic with consumer stalls
        fork
            begin : drv
                for (int i = 0; i < 1000; i++) begin
                    logic [15:0] ra, rb;
                    logic        rs;
                    int          w;
                    ra = (i % 10 == 0) ? 16'h8000 : 16'($urandom);
                    rb = (i % 13 == 0) ? 16'hFFFF : 16'($urandom);
                    if (i % 17 == 0) ra = 16'h0000;
                    rs = 1'($urandom_range(0, 1));
                    if_w16.multiplier   = ra;
                    if_w16.multiplicand = rb;
                    if_w16.in_signed    = rs;
                    if_w16.in_valid     = 1'b1;
                    w = 0;
                    @(negedge clk);
                    while (!if_w16.in_ready && w < 500) begin
                        @(negedge clk);
                        w++;
                    end
                    if (!if_w16.in_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL w16 accept timeout: in_ready 0, expected 1 at txn %0d", i);
                        break;
                    end
                    exp_q.push_back(ref_mul(rs, ra, rb));
                    @(posedge clk);
                    #1;
                    if_w16.in_valid  = 1'b0;
                    if_w16.in_signed = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin : mon
                int cyc;
                cyc = 0;
                while (got < 1000 && cyc < 50000) begin
                    @(negedge clk);
                    cyc++;
                    if (if_w16.out_valid && if_w16.out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL w16 spurious product: got 0x%0h, expected none",
                                     if_w16.product);
                        end else begin
                            check("w16 product", if_w16.product, exp_q.pop_front());
                        end
                        got++;
                    end
                    @(posedge clk);
                    #1;
                    if_w16.out_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        if_w16.out_ready = 1'b1;
        check("w16 products delivered", got, 1000);
        check("w16 products outstanding", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Iterative shift-add multiplier, parametrised in operand width, with per-transaction signed/unsigned mode.
- Computes one multiplier bit per cycle.
- Optionally terminates early once the remaining multiplier bits are zero.
- Sits beside the divider datapaths as the shared multiply resource, with valid/ready handshakes on input and output.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; minimum 2.
- EARLY_EXIT, 1, when 1 the block finishes once no set multiplier bits remain; when 0 latency is always WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands this cycle.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- multiplier  input  WIDTH  operand A.
- multiplicand  input  WIDTH  operand B.
- out_valid  output  1  product valid; held until taken.
- out_ready  input  1  consumer takes the product.
- product  output  2*WIDTH  result; stable while out_valid is high.
- busy  output  1  high in RUN.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; out_valid = 0; product = 0; busy = 0.
  - in_ready = 1 once released.
  - All internal registers are cleared.
- Reset during RUN or DONE abandons the operation; no product is delivered.
- States: IDLE, RUN, DONE (encoding lives in the package).
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Accept = in_valid && in_ready at a rising edge. On accept:
  - Capture in_signed.
  - Capture magnitude registers: unsigned mode uses the operands as-is; signed mode uses abs() of each operand, computed in WIDTH bits as unsigned (most-negative gives 2^(WIDTH-1) correctly).
  - neg_flag = in_signed && (sign of A XOR sign of B).
  - Clear the accumulator and bit counter; state goes to RUN.
- RUN, each cycle:
  - If mag_A[0] == 1, add mag_B << count into a 2*WIDTH-bit accumulator.
  - Shift mag_A right by 1; increment count.
- RUN exit: leave when count reaches WIDTH-1 on this edge. With EARLY_EXIT = 1, also leave when the shifted mag_A becomes 0.
- On the exiting edge:
  - product = neg_flag ? -(acc + addend) : (acc + addend), in 2*WIDTH bits.
  - out_valid = 1; state goes to DONE.
- Latency from the accept edge to the first cycle with out_valid high:
  - EARLY_EXIT = 0: WIDTH cycles.
  - EARLY_EXIT = 1: max(1, msb index of mag_A + 1). A zero multiplier takes 1 cycle.
- DONE:
  - Hold product and out_valid until out_ready.
  - out_ready && !in_valid: go to IDLE; out_valid drops the next cycle.
  - out_ready && in_valid: new accept on the same edge, go straight to RUN (no bubble); out_valid drops.
- in_valid while busy is ignored: in_ready is low and operands are not sampled.
- in_signed is ignored in RUN.
- Arithmetic is exact for the full range; no overflow is possible. Edge cases:
  - Signed -2^(W-1) * -2^(W-1) = 2^(2W-2), positive and fits.
  - Unsigned max*max = (2^W-1)^2.
- product keeps its last value in IDLE; it is defined only when out_valid is high.

Decomposition:
- Package seq_mult_pkg:
  - State enum (IDLE, RUN, DONE).
  - Function clog2 for counter sizing.
  - Function abs_w(value, width).
- Counter width is clog2(WIDTH).
- No sub-module is needed. The datapath (accumulator, shifter, final negate) stays in one module, and the control FSM uses a single always block.

Test Plan:
- WIDTH=8, unsigned 200*150, EARLY_EXIT=0 -> product 30000 (0x7530), out_valid exactly 8 cycles after accept.
- Signed -128 * -128 -> 16384 (0x4000). Signed -7 * 9 -> 0xFFC1 (-63). Signed 127 * -1 -> 0xFF81.
- EARLY_EXIT=1, multiplier 0 -> product 0 after 1 cycle. Multiplier 5 -> 3 cycles. Multiplier 0x80 -> 8 cycles.
- Backpressure: hold out_ready low 5 cycles -> product stable and out_valid high throughout, in_ready low. Then raise out_ready with in_valid high -> next operation accepted on the same edge with no bubble.
- rst_n pulsed low mid-RUN (cycle 3 of 8) -> out_valid 0, product 0 immediately; in_ready 1 after release; a following 3*4 returns 12.
- WIDTH=16, randomized 1000 signed/unsigned mixed transactions against a reference model, with random out_ready stalls -> all products match and none are lost or duplicated.
